spi_reg_bridge: RTL

- SPI slave front end that converts serial frames from an external host into the single-cycle register-bus accesses consumed by the BRAM register file: wr_en, rd_en, reg_addr and wdata in, rdata back.
- SCLK, CS_N and MOSI are oversampled in the clk domain, so there is no second clock domain.
- Read data returned by the register file is shifted back out on MISO in the same frame.

---
 rtl/spi_reg_bridge.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// spi_reg_bridge : mode-0 SPI slave to single-cycle register-bus bridge.
// Optional burst mode: define SPI_REG_BRIDGE_BURST_EN.
// Rev 1.0
// ============================================================================
module spi_reg_bridge #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    output logic                  busy
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        DATA_WR = 3'd2,
        DATA_RD = 3'd3,
        DONE    = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    state_t                 state_q, state_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [31:0]            shift_q, shift_d;
    logic [31:0]            tx_q, tx_d;
    logic [ADDR_WIDTH-1:0]  acc_addr_q, acc_addr_d;
    logic [ADDR_WIDTH-1:0]  reg_addr_q, reg_addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic [31:0]            shift_nx;
    logic [5:0]             cnt_inc;

    // cs_n synchronizer resets high so no frame appears to start out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign shift_nx  = {shift_q[30:0], mosi_s};
    assign cnt_inc   = bit_cnt_q + 6'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            acc_addr_q <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            acc_addr_q <= acc_addr_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        acc_addr_d = acc_addr_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;

        if (rd_en_q) begin
            tx_d = rdata;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc == 6'd16) begin
                        acc_addr_d = shift_nx[ADDR_WIDTH-1:0];
                        if (shift_nx[15]) begin
                            state_d    = DATA_RD;
                            rd_en_d    = 1'b1;
                            reg_addr_d = shift_nx[ADDR_WIDTH-1:0];
                            tx_d       = '0;
                        end else begin
                            state_d = DATA_WR;
                        end
                    end
                end
            end
            DATA_WR: begin
                if (sclk_rise) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc == 6'd48) begin
                        wr_en_d    = 1'b1;
                        wdata_d    = shift_nx;
                        reg_addr_d = acc_addr_q;
`ifdef SPI_REG_BRIDGE_BURST_EN
                        acc_addr_d = acc_addr_q + ADDR_WIDTH'(1);
                        bit_cnt_d  = 6'd16;
`else
                        state_d    = DONE;
`endif
                    end
                end
            end
            DATA_RD: begin
                // The falling edge right after a word's 16th/48th rising edge
                // must not shift, or the freshly loaded MSB would be lost.
                if (sclk_fall && bit_cnt_q >= 6'd17) begin
                    tx_d = {tx_q[30:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc == 6'd48) begin
`ifdef SPI_REG_BRIDGE_BURST_EN
                        acc_addr_d = acc_addr_q + ADDR_WIDTH'(1);
                        reg_addr_d = acc_addr_q + ADDR_WIDTH'(1);
                        rd_en_d    = 1'b1;
                        bit_cnt_d  = 6'd16;
`else
                        state_d    = DONE;
`endif
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        // A write completing in the same clk as CS_N rising still commits.
        if (state_q != IDLE && cs_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            rd_en_d   = 1'b0;
        end
    end

    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign reg_addr    = reg_addr_q;
    assign wdata       = wdata_q;
    assign busy        = ~cs_s;
    assign spi_miso_oe = ~cs_s;
    assign spi_miso    = (state_q == DATA_RD) ? tx_q[31] : 1'b0;

endmodule
`default_nettype wire
